// File: rtl/edge_threshold_counter.sv
`default_nettype none
// ============================================================================
// Module   : edge_threshold_counter
// Purpose  : Thresholds a stream of convolution-magnitude pixels into 1-bit
//            edge flags (valid/ready in, valid/ready out, 1-cycle latency)
//            and reports the number of edge pixels in each completed frame.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            en                  - permits the start of a new frame
//            threshold [W]       - edge threshold, captured at frame start
//            x_valid/x_ready/x_data [W]  - pixel input stream
//            y_valid/y_ready/y_data/y_last - edge-flag output stream
//            frame_edge_count    - edge total of the last completed frame
//            frame_done          - one-cycle pulse when the total updates
// Config   : EDGE_THRESHOLD_ABS_EN - when defined, x_data is signed and the
//            magnitude |x_data| is thresholded; otherwise x_data is unsigned.
// Revision : 1.0 - initial release
// ============================================================================
module edge_threshold_counter #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int W          = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       en,
    input  logic [W-1:0]                               threshold,
    input  logic                                       x_valid,
    output logic                                       x_ready,
    input  logic [W-1:0]                               x_data,
    output logic                                       y_valid,
    input  logic                                       y_ready,
    output logic                                       y_data,
    output logic                                       y_last,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0]  frame_edge_count,
    output logic                                       frame_done
);

    localparam int CW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t         state_q;
    logic [XW-1:0]  x_pos_q;
    logic [YW-1:0]  y_pos_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [W-1:0]   thr_q;
    logic           y_valid_q;
    logic           y_data_q;
    logic           y_last_q;
    logic [CW-1:0]  frame_edge_count_q;
    logic           frame_done_q;

    logic           ready_w;
    logic           accept_w;
    logic [W-1:0]   mag_w;
    logic [W-1:0]   thr_eff_w;
    logic           is_edge_w;
    logic           x_last_w;
    logic           is_last_w;

    // The output register can take a new pixel when it is empty or being
    // drained this cycle; a new frame may only start while en is high.
    assign ready_w  = ~rst & (y_ready | ~y_valid_q) & ((state_q == ACTIVE) | en);
    assign accept_w = x_valid & ready_w;

`ifdef EDGE_THRESHOLD_ABS_EN
    // Two's-complement negate kept at W bits: the most negative value maps
    // onto 2^(W-1), which is representable as unsigned.
    assign mag_w = x_data[W-1] ? (~x_data + {{(W-1){1'b0}}, 1'b1}) : x_data;
`else
    assign mag_w = x_data;
`endif

    // The first pixel of a frame is compared against the threshold being
    // captured on that same edge, not the stale thr_q.
    assign thr_eff_w = (state_q == IDLE) ? threshold : thr_q;
    assign is_edge_w = (mag_w >= thr_eff_w);

    assign x_last_w  = (x_pos_q == XW'(IMG_WIDTH - 1));
    assign is_last_w = x_last_w & (y_pos_q == YW'(IMG_HEIGHT - 1));

    assign cnt_d = cnt_q + {{(CW-1){1'b0}}, is_edge_w};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            x_pos_q            <= '0;
            y_pos_q            <= '0;
            cnt_q              <= '0;
            thr_q              <= '0;
            y_valid_q          <= 1'b0;
            y_data_q           <= 1'b0;
            y_last_q           <= 1'b0;
            frame_edge_count_q <= '0;
            frame_done_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (accept_w) begin
                y_valid_q <= 1'b1;
                y_data_q  <= is_edge_w;
                y_last_q  <= is_last_w;
                if (state_q == IDLE) begin
                    thr_q <= threshold;
                end
                if (is_last_w) begin
                    x_pos_q            <= '0;
                    y_pos_q            <= '0;
                    cnt_q              <= '0;
                    frame_edge_count_q <= cnt_d;
                    frame_done_q       <= 1'b1;
                    state_q            <= IDLE;
                end else begin
                    if (x_last_w) begin
                        x_pos_q <= '0;
                        y_pos_q <= y_pos_q + YW'(1);
                    end else begin
                        x_pos_q <= x_pos_q + XW'(1);
                    end
                    cnt_q   <= cnt_d;
                    state_q <= ACTIVE;
                end
            end else if (y_ready) begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign x_ready          = ready_w;
    assign y_valid          = y_valid_q;
    assign y_data           = y_data_q;
    assign y_last           = y_last_q;
    assign frame_edge_count = frame_edge_count_q;
    assign frame_done       = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_threshold_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_threshold_counter
// Purpose  : Directed self-checking bench for edge_threshold_counter with a
//            4x2 frame and 8-bit pixels. Expected flags and counts are
//            hand-computed per vector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_threshold_counter;

    localparam int IW = 4;
    localparam int IH = 2;
    localparam int W  = 8;
    localparam int CW = $clog2(IW * IH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [W-1:0]  threshold;
    logic          x_valid;
    logic          x_ready;
    logic [W-1:0]  x_data;
    logic          y_valid;
    logic          y_ready;
    logic          y_data;
    logic          y_last;
    logic [CW-1:0] frame_edge_count;
    logic          frame_done;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;

    edge_threshold_counter #(
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .W         (W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .threshold       (threshold),
        .x_valid         (x_valid),
        .x_ready         (x_ready),
        .x_data          (x_data),
        .y_valid         (y_valid),
        .y_ready         (y_ready),
        .y_data          (y_data),
        .y_last          (y_last),
        .frame_edge_count(frame_edge_count),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    // frame_done pulses are tallied on the falling edge, away from updates
    always @(negedge clk) begin
        if (frame_done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one pixel; returns just after the edge that accepted it
    task automatic push(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        x_data  = d;
        x_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (x_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        x_valid = 1'b0;
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    // Stream one full frame; pixel i is px[8*i +: 8], its edge flag exp_e[i].
    // thr2 is applied after the first pixel, en is dropped after pixel
    // en_drop, and y_ready is held low 3 cycles after pixel stall_at.
    task automatic run_frame(input string nm, input logic [63:0] px,
                             input logic [7:0] thr, input logic [7:0] thr2,
                             input int en_drop, input int stall_at,
                             input logic [7:0] exp_e, input int exp_cnt);
        int d0;
        d0 = done_cnt;
        threshold = thr;
        for (int i = 0; i < 8; i++) begin
            push(px[8*i +: 8]);
            check({nm, "_yvalid"}, y_valid, 1);
            check({nm, "_ydata"}, y_data, exp_e[i]);
            check({nm, "_ylast"}, y_last, (i == 7));
            if (i == 0) threshold = thr2;
            if (i == en_drop) en = 1'b0;
            if (i == stall_at) begin
                y_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    x_valid = 1'b1;
                    x_data  = 8'd77;
                    check({nm, "_stall_xready"}, x_ready, 0);
                    check({nm, "_stall_ydata"}, y_data, exp_e[i]);
                    check({nm, "_stall_yvalid"}, y_valid, 1);
                end
                x_valid = 1'b0;
                y_ready = 1'b1;
            end
        end
        check({nm, "_done_hi"}, frame_done, 1);
        check({nm, "_count"}, frame_edge_count, exp_cnt);
        @(posedge clk);
        #1;
        check({nm, "_done_lo"}, frame_done, 0);
        check({nm, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        rst       = 1'b1;
        en        = 1'b1;
        threshold = 8'd0;
        x_valid   = 1'b1;
        x_data    = 8'd0;
        y_ready   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_xready", x_ready, 0);
        check("rst_yvalid", y_valid, 0);
        check("rst_ydata", y_data, 0);
        check("rst_ylast", y_last, 0);
        check("rst_count", frame_edge_count, 0);
        check("rst_done", frame_done, 0);
        @(negedge clk);
        rst     = 1'b0;
        x_valid = 1'b0;

        // Basic frame: 10,50,60,49,200,0,51,255 @ 50 -> 0,1,1,0,1,0,1,1
        run_frame("basic", {8'd255, 8'd51, 8'd0, 8'd200, 8'd49, 8'd60, 8'd50, 8'd10},
                  8'd50, 8'd50, -1, -1, 8'b1101_0110, 5);

        // Threshold changed to 0 after (0,0): frame keeps 50
        run_frame("thrlatch", {8'd255, 8'd30, 8'd60, 8'd20, 8'd0, 8'd50, 8'd49, 8'd10},
                  8'd50, 8'd0, -1, -1, 8'b1010_0100, 3);
        // Next frame uses 0: every pixel is an edge
        run_frame("thrzero", 64'd0, 8'd0, 8'd0, -1, -1, 8'hFF, 8);

        // en dropped after the third pixel: frame still completes
        run_frame("endrop", {8{8'd100}}, 8'd50, 8'd50, 2, -1, 8'hFF, 8);
        d0 = done_cnt;
        @(negedge clk);
        x_valid = 1'b1;
        x_data  = 8'd200;
        repeat (3) begin
            @(negedge clk);
            check("idle_en0_xready", x_ready, 0);
        end
        check("idle_en0_yvalid", y_valid, 0);
        check("idle_en0_nodone", done_cnt - d0, 0);
        x_valid = 1'b0;
        en      = 1'b1;

        // Output stall after the first pixel
        run_frame("stall", {8'd255, 8'd51, 8'd0, 8'd200, 8'd49, 8'd60, 8'd50, 8'd60},
                  8'd50, 8'd50, -1, 0, 8'b1101_0111, 6);

        // Reset after five accepted pixels discards the partial frame
        threshold = 8'd50;
        d0 = done_cnt;
        repeat (5) push(8'd255);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_yvalid", y_valid, 0);
        check("midrst_done", frame_done, 0);
        check("midrst_count", frame_edge_count, 0);
        check("midrst_xready", x_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_nodone", done_cnt - d0, 0);
        run_frame("afterrst", {8'd255, 8'd51, 8'd0, 8'd200, 8'd49, 8'd60, 8'd50, 8'd10},
                  8'd50, 8'd50, -1, -1, 8'b1101_0110, 5);

        // Signed/unsigned interpretation: 0x9C @100 is an edge either way;
        // 0xFF is 255 unsigned (edge) but |-1| = 1 signed (not an edge)
`ifdef EDGE_THRESHOLD_ABS_EN
        run_frame("mag_a", {48'd0, 8'hFF, 8'h9C}, 8'd100, 8'd100, -1, -1, 8'b0000_0001, 1);
`else
        run_frame("mag_a", {48'd0, 8'hFF, 8'h9C}, 8'd100, 8'd100, -1, -1, 8'b0000_0011, 2);
`endif
        // 0x80 is 128 in both interpretations, below 200
        run_frame("mag_b", {56'd0, 8'h80}, 8'd200, 8'd200, -1, -1, 8'b0000_0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/edge_threshold_counter.md
EDGE_THRESHOLD_COUNTER -- requirements
Module: edge_threshold_counter

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320: pixels per row.
REQ-002 SHALL have parameter IMG_HEIGHT, default 240: rows per frame.
REQ-003 SHALL have parameter W, default 8: input pixel width, matching the upstream convolution stage output.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1: permits the start of a new frame.
REQ-007 SHALL have port threshold, input, W: edge threshold, sampled per frame.
REQ-008 SHALL have port x_valid, input, 1: upstream pixel valid.
REQ-009 SHALL have port x_ready, output, 1: block accepts a pixel.
REQ-010 SHALL have port x_data, input, W: convolution result pixel.
REQ-011 SHALL have port y_valid, output, 1: output pixel valid.
REQ-012 SHALL have port y_ready, input, 1: downstream accepts.
REQ-013 SHALL have port y_data, output, 1: edge flag.
REQ-014 SHALL have port y_last, output, 1: y_data is the last pixel of the frame.
REQ-015 SHALL have port frame_edge_count, output, $clog2(IMG_WIDTH*IMG_HEIGHT+1): edge total of the last completed frame.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse when frame_edge_count updates.

Function
REQ-017 SHALL implement FSM states IDLE and ACTIVE, with accept = x_valid && x_ready.
REQ-018 SHALL drive x_ready = (y_ready | ~y_valid) in ACTIVE, and the same term ANDed with en in IDLE.
REQ-019 SHALL move IDLE->ACTIVE on accept, latching threshold into thr_q; that first pixel SHALL be compared against the newly sampled value.
REQ-020 SHALL move ACTIVE->IDLE on accept of the pixel at x_pos=IMG_WIDTH-1, y_pos=IMG_HEIGHT-1.
REQ-021 SHALL track x_pos/y_pos row-major on accept, with wrap to (0,0) after the last pixel.
REQ-022 SHALL ignore en in ACTIVE: deasserting en mid-frame completes the frame.
REQ-023 SHALL compute edge = (mag >= thr_q), compared as W-bit unsigned, with mag per REQ-033/034.
REQ-024 SHALL load y_data=edge and y_last=(last pixel) on accept, setting y_valid=1, giving latency of exactly 1 cycle from accept to y_valid.
REQ-025 SHALL clear y_valid when y_valid && y_ready and there is no accept in the same cycle; y_data and y_last SHALL hold while y_valid && !y_ready.
REQ-026 SHALL have a simultaneous accept and output-consume load the new pixel, keeping y_valid=1.
REQ-027 SHALL increment the running count on each accepted edge pixel.
REQ-028 SHALL, on accept of the last pixel, set frame_edge_count = running count + edge, pulse frame_done for 1 cycle in the next cycle, and clear the running count.
REQ-029 SHALL never overflow the counter, since its width covers IMG_WIDTH*IMG_HEIGHT.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set state=IDLE, x_pos=y_pos=0, running count=0, thr_q=0, y_valid=0, y_data=0, y_last=0, frame_edge_count=0 and frame_done=0.
REQ-031 SHALL, on reset mid-frame, discard the partial frame with no frame_done; the next accepted pixel is (0,0).
REQ-032 SHALL hold x_ready=0 while rst=1.

Configuration
REQ-033 SHALL, with macro EDGE_THRESHOLD_ABS_EN defined, treat x_data as signed two's complement and set mag=|x_data| as W-bit unsigned (-2^(W-1) maps to 2^(W-1)).
REQ-034 SHALL, without EDGE_THRESHOLD_ABS_EN, set mag=x_data as unsigned.

Verification
Bench parameters: IMG_WIDTH=4, IMG_HEIGHT=2, W=8 unless stated.
REQ-035 SHALL cover: threshold=50, en=1, pixels 10,50,60,49,200,0,51,255 with y_ready=1 -> y_data 0,1,1,0,1,0,1,1; y_last only on the 8th; frame_edge_count=5; frame_done one pulse.
REQ-036 SHALL cover: y_ready held 0 for 3 cycles after the first output -> x_ready=0 and y_data stable throughout; no pixel lost or duplicated after release.
REQ-037 SHALL cover: threshold changed 50->0 after pixel (0,0) -> frame still uses 50; the next frame uses 0 and gives frame_edge_count=8.
REQ-038 SHALL cover: en dropped after pixel 3 -> frame completes with frame_done; en=0 in IDLE -> x_ready=0, nothing accepted.
REQ-039 SHALL cover: rst=1 after 5 accepted pixels -> y_valid=0, no frame_done; the next full frame counts from 0.
REQ-040 SHALL cover: with EDGE_THRESHOLD_ABS_EN, threshold=100, x_data=0x9C (-100) -> edge=1; without the macro, x_data=0x9C (156) -> edge=1 and x_data=0x80 with threshold=200 -> edge=0.
